cci_mpf_prim_ram_port_arb: RTL

- Shares one port of a dual-port block RAM among N_REQ requesters.
- Round-robin arbitration with a registered RAM command stage.
- Read-response routing back to the issuing requester via a latency-matched tag pipeline.
- Holds off all requesters until the RAM's initialization `rdy` asserts; sits between client logic and the RAM's port 0.

---
 rtl/cci_mpf_prim_ram_port_arb_pkg.sv | 38 +++
 rtl/cci_mpf_prim_rr_arb.sv | 41 ++++
 rtl/cci_mpf_prim_ram_port_arb.sv | 134 +++++++++++++
 3 files changed

// File: rtl/cci_mpf_prim_ram_port_arb_pkg.sv
// Shared types and the round-robin pick function for the RAM port arbiter.
// Widths are sized for the largest supported requester count (16).
package cci_mpf_prim_ram_port_arb_pkg;

  localparam int unsigned MaxReq = 16;
  localparam int unsigned IDW    = 4;

  typedef enum logic [0:0] {WAIT_RDY, RUN} t_arb_state;

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
  } t_tag;

  typedef struct packed {
    logic           found;
    logic [IDW-1:0] idx;
  } t_pick;

  // First set bit of req at ptr+1, ptr+2, ... modulo n.
  function automatic t_pick rr_pick(input logic [MaxReq-1:0] req, input logic [IDW-1:0] ptr,
                                    input int unsigned n);
    t_pick          p;
    logic [IDW-1:0] j;
    p = '0;
    for (int unsigned k = 1; k <= MaxReq; k++) begin
      if (k <= n && !p.found) begin
        j = IDW'((32'(ptr) + k) % n);
        if (req[j]) begin
          p.found = 1'b1;
          p.idx   = j;
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/cci_mpf_prim_rr_arb.sv
// N-way round-robin picker with its priority pointer register.
// The pointer rests on the last winner; the search starts one past it.
module cci_mpf_prim_rr_arb
  import cci_mpf_prim_ram_port_arb_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic           clk0,
  input  logic           reset,
  input  logic           en_i,
  input  logic [N-1:0]   req_i,
  output logic [N-1:0]   grant_o,
  output logic           grant_valid_o,
  output logic [IDW-1:0] grant_idx_o
);

  logic [IDW-1:0] ptr_q, ptr_d;
  t_pick          pick;

  always_comb begin
    pick          = rr_pick(MaxReq'(req_i), ptr_q, N);
    grant_o       = '0;
    grant_valid_o = 1'b0;
    grant_idx_o   = pick.idx;
    ptr_d         = ptr_q;
    if (en_i && pick.found) begin
      grant_o       = {{(N-1){1'b0}}, 1'b1} << pick.idx;
      grant_valid_o = 1'b1;
      ptr_d         = pick.idx;
    end
  end

  always_ff @(posedge clk0) begin
    if (reset) begin
      ptr_q <= IDW'(N - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/cci_mpf_prim_ram_port_arb.sv
// Shares RAM port 0 among N_REQ requesters with read responses routed back by tag.
// Define CCI_MPF_PRIM_RAM_PORT_ARB_STATS_EN to add conflict and per-requester grant counters.
module cci_mpf_prim_ram_port_arb
  import cci_mpf_prim_ram_port_arb_pkg::*;
#(
  parameter int unsigned N_REQ               = 4,
  parameter int unsigned N_ENTRIES           = 32,
  parameter int unsigned N_DATA_BITS         = 64,
  parameter int unsigned N_OUTPUT_REG_STAGES = 0,
  localparam int unsigned AW    = $clog2(N_ENTRIES),
  localparam int unsigned IdW   = $clog2(N_REQ),
  localparam int unsigned RdLat = 1 + N_OUTPUT_REG_STAGES
) (
  input  logic                         clk0,
  input  logic                         reset,
  input  logic                         ram_rdy,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ-1:0]             req_wen,
  input  logic [N_REQ*AW-1:0]          req_addr,
  input  logic [N_REQ*N_DATA_BITS-1:0] req_wdata,
  output logic [N_REQ-1:0]             req_grant,
  output logic                         rsp_valid,
  output logic [IdW-1:0]               rsp_id,
  output logic [N_DATA_BITS-1:0]       rsp_data,
  output logic [AW-1:0]                ram_addr,
  output logic                         ram_wen,
  output logic [N_DATA_BITS-1:0]       ram_wdata,
  input  logic [N_DATA_BITS-1:0]       ram_rdata
`ifdef CCI_MPF_PRIM_RAM_PORT_ARB_STATS_EN
  ,
  output logic [31:0]                  stat_conflict_cnt,
  output logic [N_REQ*32-1:0]          stat_grant_cnt
`endif
);

  t_arb_state state_q, state_d;
  logic       grant_valid;
  logic [IDW-1:0] grant_idx;
  logic                   wen_q, wen_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [N_DATA_BITS-1:0] wdata_q, wdata_d;
  // Index 0 travels with the command register; index RdLat lines up with ram_rdata.
  t_tag tag_q [RdLat+1];
  t_tag tag_d [RdLat+1];

  always_comb begin
    state_d = state_q;
    if (state_q == WAIT_RDY && ram_rdy) state_d = RUN;
  end

  cci_mpf_prim_rr_arb #(
    .N (N_REQ)
  ) u_rr_arb (
    .clk0          (clk0),
    .reset         (reset),
    .en_i          (state_q == RUN),
    .req_i         (req_valid),
    .grant_o       (req_grant),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

  always_comb begin
    wen_d   = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    tag_d[0].valid = 1'b0;
    tag_d[0].id    = grant_idx;
    if (grant_valid) begin
      wen_d   = req_wen[IdW'(grant_idx)];
      addr_d  = req_addr[32'(grant_idx) * AW +: AW];
      wdata_d = req_wdata[32'(grant_idx) * N_DATA_BITS +: N_DATA_BITS];
      tag_d[0].valid = !req_wen[IdW'(grant_idx)];
    end
    for (int i = 1; i <= RdLat; i++) tag_d[i] = tag_q[i-1];
  end

  always_ff @(posedge clk0) begin
    if (reset) begin
      state_q <= WAIT_RDY;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      for (int i = 0; i <= RdLat; i++) tag_q[i] <= '0;
    end else begin
      state_q <= state_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      for (int i = 0; i <= RdLat; i++) tag_q[i] <= tag_d[i];
    end
  end

  assign ram_wen   = wen_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign rsp_valid = tag_q[RdLat].valid;
  assign rsp_id    = IdW'(tag_q[RdLat].id);
  assign rsp_data  = ram_rdata;

`ifdef CCI_MPF_PRIM_RAM_PORT_ARB_STATS_EN
  logic [31:0] conflict_q, conflict_d;
  logic [31:0] gcnt_q [N_REQ];
  logic [31:0] gcnt_d [N_REQ];

  always_comb begin
    conflict_d = conflict_q;
    // x & (x-1) is nonzero exactly when two or more bits are set.
    if (state_q == RUN && (req_valid & (req_valid - 1'b1)) != '0 && conflict_q != '1) begin
      conflict_d = conflict_q + 32'd1;
    end
    for (int i = 0; i < N_REQ; i++) begin
      gcnt_d[i] = gcnt_q[i];
      if (req_grant[i] && gcnt_q[i] != '1) gcnt_d[i] = gcnt_q[i] + 32'd1;
    end
  end

  always_ff @(posedge clk0) begin
    if (reset) begin
      conflict_q <= '0;
      for (int i = 0; i < N_REQ; i++) gcnt_q[i] <= '0;
    end else begin
      conflict_q <= conflict_d;
      for (int i = 0; i < N_REQ; i++) gcnt_q[i] <= gcnt_d[i];
    end
  end

  assign stat_conflict_cnt = conflict_q;
  for (genvar g = 0; g < N_REQ; g++) begin : g_stat
    assign stat_grant_cnt[g*32 +: 32] = gcnt_q[g];
  end
`endif

endmodule
